// File: rtl/dac_spi_master.sv
// Per-DAC SPI transmitter: pops one word per frame from the channel FIFO and
// shifts it MSB first on SCLK/MOSI, framed by active-low SYNC_n.
module dac_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned WORD_W  = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_transmit,
  input  logic [WORD_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_read,
  output logic              busy,
  output logic              frame_done,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_sync_n
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned BIT_W = $clog2(WORD_W + 1);
  localparam int unsigned GAP_W = 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                fifo_read_d;
  logic                frame_done_d;
  logic                sclk_d;
  logic                mosi_d;
  logic                sync_n_d;

  // Anything past IDLE owns a popped word, so busy covers the pop cycle too.
  assign busy = (state_q != S_IDLE);

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      fifo_read  <= 1'b0;
      frame_done <= 1'b0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_sync_n <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      fifo_read  <= fifo_read_d;
      frame_done <= frame_done_d;
      spi_sclk   <= sclk_d;
      spi_mosi   <= mosi_d;
      spi_sync_n <= sync_n_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    div_d        = div_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    fifo_read_d  = 1'b0;
    frame_done_d = 1'b0;
    sclk_d       = spi_sclk;
    mosi_d       = spi_mosi;
    sync_n_d     = spi_sync_n;

    unique case (state_q)
      S_IDLE: begin
        if (start_transmit && !fifo_empty) begin
          fifo_read_d = 1'b1;
          state_d     = S_POP;
        end
      end

      S_POP: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d  = fifo_rdata;
        mosi_d   = fifo_rdata[WORD_W-1];
        sync_n_d = 1'b0;
        div_d    = '0;
        bit_d    = '0;
        state_d  = S_SHIFT;
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~spi_sclk;
          // Falling toggle: the DAC has just sampled the current bit.
          if (spi_sclk) begin
            bit_d = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) begin
              state_d = S_HOLD;
            end else begin
              shift_d = {shift_q[WORD_W-2:0], 1'b0};
              mosi_d  = shift_q[WORD_W-2];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d        = '0;
          sync_n_d     = 1'b1;
          frame_done_d = 1'b1;
          mosi_d       = 1'b0;
          gap_d        = '0;
          state_d      = S_GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dac_spi_master.sv
// Bench for dac_spi_master: queue-backed FIFO, frame-offset output model
// checked every cycle, plus a falling-edge SPI receiver with literal checks.
module tb_dac_spi_master;

  localparam int CD  = 2;
  localparam int GAP = 2;
  localparam int W   = 24;
  localparam int NBC = W * 2 * CD;      // SHIFT cycles per frame
  localparam int L   = NBC + CD;        // SYNC_n low cycles
  localparam int F   = 2 + L + GAP;     // POP..last GAP cycle

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start_transmit = 1'b0;
  logic [W-1:0] fifo_rdata = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_read, busy, frame_done, spi_sclk, spi_mosi, spi_sync_n;

  dac_spi_master #(.CLK_DIV(CD), .CS_GAP(GAP), .WORD_W(W)) dut (
    .clock(clock), .reset(reset), .start_transmit(start_transmit),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .busy(busy), .frame_done(frame_done), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_sync_n(spi_sync_n)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Expected {fifo_read, busy, frame_done, sclk, mosi, sync_n} at frame offset k.
  function automatic logic [5:0] model_out(input bit idle, input int k, input logic [W-1:0] w);
    int   j;
    int   b;
    logic sc;
    logic mo;
    if (idle) return 6'b000001;
    if (k == 0) return 6'b110001;
    if (k == 1) return 6'b010001;
    if (k < 2 + L) begin
      j = k - 2;
      if (j < NBC) begin
        b  = j / (2 * CD);
        sc = (j % (2 * CD)) >= CD;
        mo = w[W-1-b];
      end else begin
        sc = 1'b0;
        mo = w[0];
      end
      return {1'b0, 1'b1, 1'b0, sc, mo, 1'b0};
    end
    return {1'b0, 1'b1, (k == 2 + L), 1'b0, 1'b0, 1'b1};
  endfunction

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] rx_q[$];
  bit           model_on = 1'b0;
  bit           m_idle = 1'b1;
  int           m_k = 0;
  logic [W-1:0] m_word = '0;

  int           rd_count = 0;
  int           done_count = 0;
  int           rx_bits = 0;
  logic [W-1:0] rx_sh = '0;
  int           run = 0;
  int           last_high_run = 0;
  logic         prev_sclk = 1'b0;
  logic         prev_mosi = 1'b0;
  logic         prev_sync = 1'b1;

  logic [5:0] outs;
  assign outs = {fifo_read, busy, frame_done, spi_sclk, spi_mosi, spi_sync_n};

  // Mid-cycle: compare, monitor the link, serve the FIFO, advance the model.
  always @(negedge clock) begin
    if (model_on) begin
      chk("cycle", 32'(outs), 32'(model_out(m_idle, m_k, m_word)));
      chk("busy_cov", 32'(fifo_empty & ~busy & ~spi_sync_n), 32'd0);
      if (fifo_read) rd_count++;
      if (frame_done) done_count++;
      if (prev_sclk && !spi_sclk) begin
        rx_sh = {rx_sh[W-2:0], prev_mosi};
        rx_bits++;
      end
      if (spi_sync_n != prev_sync) begin
        if (!spi_sync_n) begin
          last_high_run = run;
          rx_bits = 0;
        end else if (rx_bits == W) begin
          rx_q.push_back(rx_sh);
          chk("sync_low_len", 32'(run), 32'd98);
        end
        run = 0;
      end
      run++;
      prev_sclk = spi_sclk;
      prev_mosi = spi_mosi;
      prev_sync = spi_sync_n;
    end

    if (fifo_read === 1'b1 && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);

    if (reset) begin
      m_idle = 1'b1;
    end else if (m_idle) begin
      if (start_transmit && !fifo_empty) begin
        m_idle = 1'b0;
        m_k    = 0;
        m_word = fifo_q[0];
      end
    end else if (m_k == F - 1) begin
      m_idle = 1'b1;
    end else begin
      m_k++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  int           rd0;
  int           rx0;
  int           dn0;
  logic [W-1:0] w0, w1, w2;

  initial begin
    step(1);
    chk("reset_state", 32'(outs), 32'h01);
    model_on = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);

    // Single word, one-cycle start pulse.
    rd0 = rd_count; rx0 = rx_q.size(); dn0 = done_count;
    push(24'hA5F00F);
    start_transmit = 1'b1;
    step(1);
    start_transmit = 1'b0;
    step(110);
    chk("single_reads", 32'(rd_count - rd0), 32'd1);
    chk("single_rx_cnt", 32'(rx_q.size() - rx0), 32'd1);
    chk("single_word", 32'(rx_q[rx0]), 32'hA5F00F);
    chk("single_done", 32'(done_count - dn0), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);

    // Back-to-back with start held high.
    rd0 = rd_count; rx0 = rx_q.size();
    push(24'h000000);
    push(24'hFFFFFF);
    start_transmit = 1'b1;
    step(215);
    start_transmit = 1'b0;
    chk("bb_reads", 32'(rd_count - rd0), 32'd2);
    chk("bb_rx_cnt", 32'(rx_q.size() - rx0), 32'd2);
    chk("bb_word0", 32'(rx_q[rx0]), 32'h000000);
    chk("bb_word1", 32'(rx_q[rx0+1]), 32'hFFFFFF);
    chk("bb_gap", 32'(last_high_run), 32'd5);

    // Empty FIFO with start high.
    rd0 = rd_count;
    start_transmit = 1'b1;
    step(100);
    start_transmit = 1'b0;
    chk("empty_reads", 32'(rd_count - rd0), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_sync", 32'(spi_sync_n), 32'd1);

    // Start dropped during bit 5 of the first frame.
    w0 = 24'($urandom); w1 = 24'($urandom); w2 = 24'($urandom);
    rd0 = rd_count; rx0 = rx_q.size();
    push(w0); push(w1); push(w2);
    start_transmit = 1'b1;
    step(24);
    start_transmit = 1'b0;
    step(110);
    chk("drop_reads", 32'(rd_count - rd0), 32'd1);
    chk("drop_word", 32'(rx_q[rx0]), 32'(w0));
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_left", 32'(fifo_q.size()), 32'd2);

    // Reset during bit 10; the popped word is lost, the next one goes out whole.
    rd0 = rd_count; rx0 = rx_q.size();
    start_transmit = 1'b1;
    step(44);
    reset = 1'b1;
    step(1);
    chk("rst_outs", 32'(outs), 32'h01);
    reset = 1'b0;
    step(110);
    start_transmit = 1'b0;
    chk("rst_reads", 32'(rd_count - rd0), 32'd2);
    chk("rst_rx_cnt", 32'(rx_q.size() - rx0), 32'd1);
    chk("rst_word", 32'(rx_q[rx0]), 32'(w2));
    step(5);

    // Random start/push traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start_transmit = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) push(24'($urandom));
      step(1);
    end
    start_transmit = 1'b0;
    step(110);
    chk("rand_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
